// File: rtl/seven_seg_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seven_seg_scan_pkg
// Brief   : Segment pattern constants and shared types for the 7-seg scanner.
// Revision: 1.0 - initial release
// ============================================================================
package seven_seg_scan_pkg;

  typedef logic [6:0] seg_t;    // {g,f,e,d,c,b,a}, active-low
  typedef logic [3:0] anode_t;  // anode[i] selects digit i, active-low

  localparam seg_t c_seg_0    = 7'b1000000;
  localparam seg_t c_seg_1    = 7'b1111001;
  localparam seg_t c_seg_2    = 7'b0100100;
  localparam seg_t c_seg_3    = 7'b0110000;
  localparam seg_t c_seg_4    = 7'b0011001;
  localparam seg_t c_seg_5    = 7'b0010010;
  localparam seg_t c_seg_6    = 7'b0000010;
  localparam seg_t c_seg_7    = 7'b1111000;
  localparam seg_t c_seg_8    = 7'b0000000;
  localparam seg_t c_seg_9    = 7'b0010000;
  localparam seg_t c_seg_dash = 7'b0111111;
  localparam seg_t c_seg_off  = 7'h7F;

  localparam anode_t c_anode_off = 4'hF;

  // Active-low one-hot select for the digit being scanned.
  function automatic anode_t anode_sel(input logic [1:0] idx);
    return ~(anode_t'(1) << idx);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_scan_if.sv
`default_nettype none
// ============================================================================
// Module  : seven_seg_scan_if
// Brief   : Digit inputs, display controls and panel drive of the scanner.
// Revision: 1.0 - initial release
// ============================================================================
interface seven_seg_scan_if;
  import seven_seg_scan_pkg::*;

  logic       en;
  logic [3:0] d0;
  logic [2:0] d1;
  logic [3:0] d2;
  logic [1:0] d3;
  logic [3:0] blink_mask;
  logic       dp_en;
  seg_t       seg;
  anode_t     anode;
  logic       dp;

  modport master (
    output en, d0, d1, d2, d3, blink_mask, dp_en,
    input  seg, anode, dp
  );

  modport slave (
    input  en, d0, d1, d2, d3, blink_mask, dp_en,
    output seg, anode, dp
  );

endinterface
`default_nettype wire

// File: rtl/seven_seg_scan_bcd_to_seg.sv
`default_nettype none
// ============================================================================
// Module  : bcd_to_seg
// Brief   : 4-bit value to active-low 7-segment pattern; 10-15 shows a dash.
// Revision: 1.0 - initial release
// ============================================================================
module bcd_to_seg
  import seven_seg_scan_pkg::*;
(
  input  wire logic [3:0] value,
  output seg_t            seg
);

  always_comb begin
    seg = c_seg_dash;
    case (value)
      4'd0:    seg = c_seg_0;
      4'd1:    seg = c_seg_1;
      4'd2:    seg = c_seg_2;
      4'd3:    seg = c_seg_3;
      4'd4:    seg = c_seg_4;
      4'd5:    seg = c_seg_5;
      4'd6:    seg = c_seg_6;
      4'd7:    seg = c_seg_7;
      4'd8:    seg = c_seg_8;
      4'd9:    seg = c_seg_9;
      default: seg = c_seg_dash;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module  : seven_seg_scan
// Brief   : Time-multiplexed HH:MM driver for a 4-digit common-anode display.
// Revision: 1.0 - initial release
// ============================================================================
module seven_seg_scan
  import seven_seg_scan_pkg::*;
#(
  parameter int SCAN_DIV    = 100000,
  parameter int BLINK_DIV   = 25000000,
  parameter int LZ_SUPPRESS = 1
) (
  input  wire logic        clk,
  input  wire logic        rst,
  seven_seg_scan_if.slave  bus
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [SW-1:0] c_scan_last  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] c_blink_last = BW'(BLINK_DIV - 1);

  logic [SW-1:0] r_scan_cnt;
  logic [1:0]    r_idx;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_phase;
  logic [3:0]    r_sh0;
  logic [2:0]    r_sh1;
  logic [3:0]    r_sh2;
  logic [1:0]    r_sh3;
  seg_t          r_seg;
  anode_t        r_anode;
  logic          r_dp;

  logic          w_tick;
  logic          w_blink_tc;
  logic [3:0]    w_value;
  seg_t          w_digit_seg;
  logic          w_blink_off;
  logic          w_lz_blank;
  logic          w_visible;

  assign w_tick     = (r_scan_cnt == c_scan_last);
  assign w_blink_tc = (r_blink_cnt == c_blink_last);

  always_comb begin
    w_value = 4'd0;
    case (r_idx)
      2'd0:    w_value = r_sh0;
      2'd1:    w_value = {1'b0, r_sh1};
      2'd2:    w_value = r_sh2;
      default: w_value = {2'b00, r_sh3};
    endcase
  end

  bcd_to_seg u_dec (
    .value (w_value),
    .seg   (w_digit_seg)
  );

  // Slot position 0 is always dark so the previous digit cannot ghost.
  assign w_blink_off = bus.blink_mask[r_idx] && !r_blink_phase;
  assign w_lz_blank  = (LZ_SUPPRESS != 0) && (r_idx == 2'd3) && (r_sh3 == 2'd0);
  assign w_visible   = (r_scan_cnt != '0) && bus.en && !w_blink_off && !w_lz_blank;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt    <= '0;
      r_idx         <= 2'd0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
      r_sh0         <= '0;
      r_sh1         <= '0;
      r_sh2         <= '0;
      r_sh3         <= '0;
    end else begin
      r_scan_cnt <= w_tick ? '0 : r_scan_cnt + SW'(1);
      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
        // Snapshot at frame end keeps a whole frame consistent.
        if (r_idx == 2'd3) begin
          r_sh0 <= bus.d0;
          r_sh1 <= bus.d1;
          r_sh2 <= bus.d2;
          r_sh3 <= bus.d3;
        end
      end
      if (w_blink_tc) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg   <= c_seg_off;
      r_anode <= c_anode_off;
      r_dp    <= 1'b1;
    end else begin
      r_seg   <= w_visible ? w_digit_seg : c_seg_off;
      r_anode <= w_visible ? anode_sel(r_idx) : c_anode_off;
      r_dp    <= ~(w_visible && (r_idx == 2'd2) && bus.dp_en);
    end
  end

  assign bus.seg   = r_seg;
  assign bus.anode = r_anode;
  assign bus.dp    = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module  : tb_seven_seg_scan
// Brief   : Self-checking bench for seven_seg_scan against a timeline model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan;

  localparam int SD = 4;
  localparam int BD = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seven_seg_scan_if bus ();
  seven_seg_scan_if bus2 ();

  assign bus2.en         = bus.en;
  assign bus2.d0         = bus.d0;
  assign bus2.d1         = bus.d1;
  assign bus2.d2         = bus.d2;
  assign bus2.d3         = bus.d3;
  assign bus2.blink_mask = bus.blink_mask;
  assign bus2.dp_en      = bus.dp_en;

  seven_seg_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD), .LZ_SUPPRESS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  seven_seg_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD), .LZ_SUPPRESS(0)) dut_nolz (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string nm, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: time since reset fully determines slot, digit and blink phase.
  int         m_k = 0;
  bit         m_valid = 1'b0;
  logic [3:0] m_sh [4];
  logic [6:0] exp_seg;
  logic [3:0] exp_anode;
  logic       exp_dp;
  int         m_slot, m_dig;
  bit         m_ph, m_vis;

  function automatic logic [6:0] pattern(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_k = 0;
      for (int i = 0; i < 4; i++) m_sh[i] = 4'd0;
      exp_seg   = 7'h7F;
      exp_anode = 4'hF;
      exp_dp    = 1'b1;
      m_valid   = 1'b1;
    end else begin
      m_slot = m_k % SD;
      m_dig  = (m_k / SD) % 4;
      m_ph   = ((m_k / BD) % 2) == 0;
      m_vis  = (m_slot != 0) && bus.en && !(bus.blink_mask[m_dig] && !m_ph)
               && !(m_dig == 3 && m_sh[3] == 4'd0);
      exp_anode = 4'hF;
      if (m_vis) exp_anode[m_dig] = 1'b0;
      exp_seg = m_vis ? pattern(m_sh[m_dig]) : 7'h7F;
      exp_dp  = !(m_vis && m_dig == 2 && bus.dp_en);
      if (m_slot == SD - 1 && m_dig == 3) begin
        m_sh[0] = bus.d0;
        m_sh[1] = {1'b0, bus.d1};
        m_sh[2] = bus.d2;
        m_sh[3] = {2'b00, bus.d3};
      end
      m_k++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("seg", bus.seg, exp_seg);
      check("anode", {3'b000, bus.anode}, {3'b000, exp_anode});
      check("dp", {6'd0, bus.dp}, {6'd0, exp_dp});
    end
  end

  // Wait until the outputs show the result of scan state k.
  task automatic at_state(input int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_k != k + 1 && n < 2000);
    if (m_k != k + 1) begin
      n_mis++;
      $display("FAIL at_state timeout: got k=%0d expected k=%0d", m_k - 1, k);
    end
  endtask

  initial begin
    bus.en = 1'b1;
    bus.d0 = 4'd0; bus.d1 = 3'd0; bus.d2 = 4'd0; bus.d3 = 2'd0;
    bus.blink_mask = 4'b0000;
    bus.dp_en = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_seg", bus.seg, 7'h7F);
    check("rst_anode", {3'b000, bus.anode}, 7'h0F);
    check("rst_dp", {6'd0, bus.dp}, 7'd1);
    rst = 1'b0;

    at_state(0);
    check("first_blank", {3'b000, bus.anode}, 7'h0F);
    at_state(1);
    check("first_d0_anode", {3'b000, bus.anode}, 7'b0001110);
    check("first_d0_seg", bus.seg, 7'b1000000);
    at_state(4);
    bus.d3 = 2'd1; bus.d2 = 4'd2; bus.d1 = 3'd3; bus.d0 = 4'd4;

    at_state(17);
    check("f2_d0_seg", bus.seg, 7'b0011001);
    check("f2_d0_anode", {3'b000, bus.anode}, 7'b0001110);
    at_state(18);
    bus.d1 = 3'd5;
    at_state(21);
    check("f2_d1_old", bus.seg, 7'b0110000);
    at_state(25);
    check("f2_d2_seg", bus.seg, 7'b0100100);
    at_state(28);
    check("f2_blank", {3'b000, bus.anode}, 7'h0F);
    at_state(29);
    check("f2_d3_seg", bus.seg, 7'b1111001);
    check("f2_d3_anode", {3'b000, bus.anode}, 7'b0000111);
    at_state(37);
    check("f3_d1_new", bus.seg, 7'b0010010);
    check("f3_d1_anode", {3'b000, bus.anode}, 7'b0001101);
    at_state(38);
    bus.blink_mask = 4'b0011;
    bus.dp_en = 1'b1;

    at_state(41);
    check("f3_dp_on", {6'd0, bus.dp}, 7'd0);
    at_state(45);
    check("f3_dp_off", {6'd0, bus.dp}, 7'd1);
    at_state(49);
    check("f4_d0_blinked", {3'b000, bus.anode}, 7'h0F);
    at_state(53);
    check("f4_d1_blinked", {3'b000, bus.anode}, 7'h0F);
    at_state(57);
    check("f4_d2_anode", {3'b000, bus.anode}, 7'b0001011);
    check("f4_d2_dp", {6'd0, bus.dp}, 7'd0);
    at_state(61);
    check("f4_d3_anode", {3'b000, bus.anode}, 7'b0000111);
    at_state(65);
    check("f5_d0_back", {3'b000, bus.anode}, 7'b0001110);
    at_state(66);
    bus.d0 = 4'hC; bus.d3 = 2'd0;
    bus.blink_mask = 4'b0000; bus.dp_en = 1'b0;

    at_state(81);
    check("dash_seg", bus.seg, 7'b0111111);
    at_state(93);
    check("lz_anode", {3'b000, bus.anode}, 7'h0F);
    check("nolz_seg", bus2.seg, 7'b1000000);
    check("nolz_anode", {3'b000, bus2.anode}, 7'b0000111);

    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      bus.d0 = 4'($urandom_range(0, 15));
      bus.d1 = 3'($urandom_range(0, 5));
      bus.d2 = 4'($urandom_range(0, 15));
      bus.d3 = 2'($urandom_range(0, 3));
      bus.en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) bus.blink_mask = 4'($urandom_range(0, 15));
      bus.dp_en = 1'($urandom_range(0, 1));
    end

    bus.en = 1'b1; bus.blink_mask = 4'b0000;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (((m_k / SD) % 4) != 2 && n < 100);
      if (((m_k / SD) % 4) != 2) begin
        n_mis++;
        $display("FAIL idx2_wait timeout: got idx=%0d expected 2", (m_k / SD) % 4);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_seg", bus.seg, 7'h7F);
    check("midrst_anode", {3'b000, bus.anode}, 7'h0F);
    check("midrst_dp", {6'd0, bus.dp}, 7'd1);
    at_state(0);
    check("midrst_blank", {3'b000, bus.anode}, 7'h0F);
    at_state(1);
    check("midrst_d0_anode", {3'b000, bus.anode}, 7'b0001110);
    check("midrst_d0_seg", bus.seg, 7'b1000000);
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
